// File: rtl/dla_pe_result_merge_pkg.sv
// Shared types and derived widths for the multi-array PE result merger.
package dla_pe_result_merge_pkg;

    typedef enum logic {
        MERGE_RR     = 1'b0,
        MERGE_STRICT = 1'b1
    } merge_mode_e;

    typedef struct packed {
        int unsigned num_arrays;
        int unsigned data_width;
        int unsigned fifo_depth;
        int unsigned almost_full_slack;
        int unsigned burst_width;
    } merge_arch_t;

    localparam merge_arch_t DEFAULT_ARCH = '{
        num_arrays:        2,
        data_width:        512,
        fifo_depth:        32,
        almost_full_slack: 8,
        burst_width:       16
    };

    // Slice id is at least one bit wide so a single-array build still has a port.
    function automatic int id_width(input int num_arrays);
        return (num_arrays > 2) ? $clog2(num_arrays) : 1;
    endfunction

    function automatic int occ_width(input int fifo_depth);
        return $clog2(fifo_depth + 1);
    endfunction

endpackage

// File: rtl/dla_pe_result_merge_fifo.sv
// One slice buffer: storage, occupancy, registered almost-full and sticky overflow.
// A write into a full buffer is still accepted when the head is popped in the same cycle.
module dla_pe_result_merge_fifo
    import dla_pe_result_merge_pkg::*;
#(
    parameter int DATA_WIDTH        = 512,
    parameter int FIFO_DEPTH        = 32,
    parameter int ALMOST_FULL_SLACK = 8
) (
    input  logic                  clk,
    input  logic                  i_sclr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = occ_width(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] AF_C    = OCC_W'(FIFO_DEPTH - ALMOST_FULL_SLACK);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      occ_next;
    logic                  push;
    logic                  drop;

    assign push    = i_valid && ((occ != DEPTH_C) || i_pop);
    assign drop    = i_valid && (occ == DEPTH_C) && !i_pop;
    assign o_head  = mem[rd_ptr];
    assign o_empty = (occ == '0);

    always_comb begin
        occ_next = occ;
        if (push && !i_pop) begin
            occ_next = occ + OCC_W'(1);
        end else if (i_pop && !push) begin
            occ_next = occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !i_sclr) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ           <= occ_next;
            o_almost_full <= (occ_next >= AF_C);
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dla_pe_result_merge.sv
// Merges NUM_ARRAYS non-stallable slice result streams into one ready/valid stream,
// draining the slice buffers round-robin or in strict in-order bursts.
module dla_pe_result_merge
    import dla_pe_result_merge_pkg::*;
#(
    parameter int NUM_ARRAYS        = DEFAULT_ARCH.num_arrays,
    parameter int DATA_WIDTH        = DEFAULT_ARCH.data_width,
    parameter int FIFO_DEPTH        = DEFAULT_ARCH.fifo_depth,
    parameter int ALMOST_FULL_SLACK = DEFAULT_ARCH.almost_full_slack,
    parameter int BURST_WIDTH       = DEFAULT_ARCH.burst_width,
    parameter int ID_W              = id_width(NUM_ARRAYS)
) (
    input  logic                             clk,
    input  logic                             i_sclr,
    input  logic                             i_mode,
    input  logic [BURST_WIDTH-1:0]           i_burst_len,
    input  logic [NUM_ARRAYS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_ARRAYS-1:0]            i_valid,
    output logic [NUM_ARRAYS-1:0]            o_almost_full,
    output logic [NUM_ARRAYS-1:0]            o_overflow,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [ID_W-1:0]                  o_array_id,
    output logic                             o_valid,
    input  logic                             i_ready
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_ARRAYS - 1);

    logic [NUM_ARRAYS-1:0] empty;
    logic [NUM_ARRAYS-1:0] pop;
    logic [DATA_WIDTH-1:0] head [NUM_ARRAYS];

    merge_mode_e           mode_q;
    logic [BURST_WIDTH-1:0] burst_q;
    logic [BURST_WIDTH-1:0] beat_q;
    logic [BURST_WIDTH-1:0] burst_eff;
    logic [ID_W-1:0]       cur_q;
    logic [ID_W-1:0]       last_q;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_valid;
    logic                  idle;
    logic                  load;

    for (genvar k = 0; k < NUM_ARRAYS; k++) begin : g_slice
        dla_pe_result_merge_fifo #(
            .DATA_WIDTH       (DATA_WIDTH),
            .FIFO_DEPTH       (FIFO_DEPTH),
            .ALMOST_FULL_SLACK(ALMOST_FULL_SLACK)
        ) u_fifo (
            .clk          (clk),
            .i_sclr       (i_sclr),
            .i_data       (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_valid      (i_valid[k]),
            .i_pop        (pop[k]),
            .o_head       (head[k]),
            .o_empty      (empty[k]),
            .o_almost_full(o_almost_full[k]),
            .o_overflow   (o_overflow[k])
        );
    end

    assign idle      = (&empty) && !o_valid;
    assign load      = !o_valid || i_ready;
    assign burst_eff = (burst_q == '0) ? BURST_WIDTH'(1) : burst_q;

    // Strict mode waits on CUR even when other slices hold data.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        if (mode_q == MERGE_STRICT) begin
            grant_id    = cur_q;
            grant_valid = !empty[cur_q];
        end else begin
            for (int i = 1; i <= NUM_ARRAYS; i++) begin
                idx = (int'(last_q) + i) % NUM_ARRAYS;
                if (!grant_valid && !empty[idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < NUM_ARRAYS; k++) begin
            pop[k] = load && grant_valid && (grant_id == ID_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            mode_q  <= MERGE_RR;
            burst_q <= BURST_WIDTH'(1);
            cur_q   <= '0;
            beat_q  <= '0;
            last_q  <= LAST_ID;
        end else if (idle) begin
            mode_q  <= merge_mode_e'(i_mode);
            burst_q <= i_burst_len;
            cur_q   <= '0;
            beat_q  <= '0;
            last_q  <= LAST_ID;
        end else if (load && grant_valid) begin
            last_q <= grant_id;
            if (mode_q == MERGE_STRICT) begin
                if (beat_q + BURST_WIDTH'(1) == burst_eff) begin
                    beat_q <= '0;
                    cur_q  <= (cur_q == LAST_ID) ? '0 : cur_q + ID_W'(1);
                end else begin
                    beat_q <= beat_q + BURST_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_array_id <= '0;
        end else if (load) begin
            o_valid <= grant_valid;
            if (grant_valid) begin
                o_data     <= head[grant_id];
                o_array_id <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_dla_pe_result_merge.sv
// Directed self-checking bench for dla_pe_result_merge (2 slices, depth 8, slack 2).
module tb_dla_pe_result_merge;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int BW = 16;

    logic            clk = 1'b0;
    logic            i_sclr;
    logic            i_mode;
    logic [BW-1:0]   i_burst_len;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    o_almost_full;
    logic [N-1:0]    o_overflow;
    logic [DW-1:0]   o_data;
    logic            o_array_id;
    logic            o_valid;
    logic            i_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int            q_id[$];
    logic [DW-1:0] q_data[$];
    int            q_cyc[$];

    dla_pe_result_merge #(
        .NUM_ARRAYS       (N),
        .DATA_WIDTH       (DW),
        .FIFO_DEPTH       (8),
        .ALMOST_FULL_SLACK(2),
        .BURST_WIDTH      (BW)
    ) dut (
        .clk          (clk),
        .i_sclr       (i_sclr),
        .i_mode       (i_mode),
        .i_burst_len  (i_burst_len),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_almost_full(o_almost_full),
        .o_overflow   (o_overflow),
        .o_data       (o_data),
        .o_array_id   (o_array_id),
        .o_valid      (o_valid),
        .i_ready      (i_ready)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so the negedge view is the handshake.
    always @(negedge clk) begin
        cyc++;
        if (!i_sclr && o_valid && i_ready) begin
            q_id.push_back(int'(o_array_id));
            q_data.push_back(o_data);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = '0;
        i_data  = '0;
    endtask

    task automatic clear_q();
        q_id.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        i_sclr = 1'b1;
        idle_inputs();
        tick();
        tick();
        i_sclr = 1'b0;
        clear_q();
    endtask

    task automatic check_q_entry(input int i, input int exp_id, input logic [DW-1:0] exp_d);
        checks++;
        if (q_id[i] !== exp_id || q_data[i] !== exp_d) begin
            errors++;
            $display("FAIL beat[%0d]: got id=%0d data=%0h, expected id=%0d data=%0h",
                     i, q_id[i], q_data[i], exp_id, exp_d);
        end
    endtask

    task automatic check_q_size(input string name, input int exp_n);
        checks++;
        if (q_id.size() != exp_n) begin
            errors++;
            $display("FAIL %s beat count: got %0d expected %0d", name, q_id.size(), exp_n);
        end
    endtask

    task automatic test_reset();
        i_ready     = 1'b1;
        i_mode      = 1'b0;
        i_burst_len = 16'd1;
        do_reset();
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_array_id !== 1'b0 ||
            o_almost_full !== '0 || o_overflow !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%0h id=%b af=%b ovf=%b expected all zero",
                     o_valid, o_data, o_array_id, o_almost_full, o_overflow);
        end
        i_data  = {16'h0, 16'hA1};
        i_valid = 2'b01;
        tick();
        idle_inputs();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_t1: got o_valid=%b expected 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'hA1 || o_array_id !== 1'b0) begin
            errors++;
            $display("FAIL latency_t2: got v=%b d=%0h id=%b expected v=1 d=a1 id=0",
                     o_valid, o_data, o_array_id);
        end
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        i_mode  = 1'b0;
        i_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            i_data  = {16'(16'h20 + i), 16'(16'h10 + i)};
            i_valid = 2'b11;
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        check_q_size("rr", 6);
        if (q_id.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check_q_entry(i, i % 2, 16'(((i % 2) != 0 ? 16'h20 : 16'h10) + i / 2));
                checks++;
                if (q_cyc[i] != q_cyc[0] + i) begin
                    errors++;
                    $display("FAIL rr_back_to_back[%0d]: got cycle %0d expected %0d",
                             i, q_cyc[i], q_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_strict();
        int            exp_id[8];
        logic [DW-1:0] exp_d[8];
        exp_id = '{0, 0, 1, 1, 0, 0, 1, 1};
        exp_d  = '{16'h40, 16'h41, 16'h30, 16'h31, 16'h42, 16'h43, 16'h32, 16'h33};
        do_reset();
        i_mode      = 1'b1;
        i_burst_len = 16'd2;
        i_ready     = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            i_data  = {16'(16'h30 + i), 16'h0};
            i_valid = 2'b10;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL strict_wait_cur[%0d]: got o_valid=%b expected 0", i, o_valid);
            end
        end
        for (int i = 0; i < 2; i++) begin
            i_data  = {16'h0, 16'(16'h40 + i)};
            i_valid = 2'b01;
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        check_q_size("strict_first", 4);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL strict_stall: got o_valid=%b expected 0", o_valid);
        end
        for (int i = 0; i < 2; i++) begin
            i_data  = {16'h0, 16'(16'h42 + i)};
            i_valid = 2'b01;
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        check_q_size("strict_total", 8);
        if (q_id.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_q_entry(i, exp_id[i], exp_d[i]);
            end
        end
        i_mode      = 1'b0;
        i_burst_len = 16'd1;
    endtask

    task automatic test_almost_full_overflow();
        do_reset();
        i_mode  = 1'b0;
        i_ready = 1'b0;
        tick();
        // Park a slice-1 beat in the output register so slice 0 keeps all of its writes.
        i_data  = {16'h5F, 16'h0};
        i_valid = 2'b10;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_array_id !== 1'b1) begin
            errors++;
            $display("FAIL af_park: got v=%b id=%b expected v=1 id=1", o_valid, o_array_id);
        end
        for (int i = 0; i < 9; i++) begin
            i_data  = {16'h0, 16'(16'h50 + i)};
            i_valid = 2'b01;
            tick();
            if (i == 4 || i == 5) begin
                checks++;
                if (o_almost_full[0] !== (i == 5)) begin
                    errors++;
                    $display("FAIL almost_full after write %0d: got %b expected %b",
                             i + 1, o_almost_full[0], (i == 5));
                end
            end
            if (i == 7 || i == 8) begin
                checks++;
                if (o_overflow[0] !== (i == 8)) begin
                    errors++;
                    $display("FAIL overflow after write %0d: got %b expected %b",
                             i + 1, o_overflow[0], (i == 8));
                end
            end
        end
        idle_inputs();
        i_ready = 1'b1;
        repeat (15) tick();
        check_q_size("ovf_drain", 9);
        if (q_id.size() == 9) begin
            check_q_entry(0, 1, 16'h5F);
            for (int i = 1; i < 9; i++) begin
                check_q_entry(i, 0, 16'(16'h50 + i - 1));
            end
        end
        checks++;
        if (o_overflow !== 2'b01 || o_almost_full !== 2'b00) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b af=%b expected ovf=01 af=00",
                     o_overflow, o_almost_full);
        end
    endtask

    task automatic test_full_write_with_pop();
        do_reset();
        i_ready = 1'b0;
        tick();
        i_data  = {16'h6F, 16'h0};
        i_valid = 2'b10;
        tick();
        idle_inputs();
        tick();
        for (int i = 0; i < 8; i++) begin
            i_data  = {16'h0, 16'(16'h60 + i)};
            i_valid = 2'b01;
            tick();
        end
        checks++;
        if (o_overflow[0] !== 1'b0 || o_almost_full[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: got ovf=%b af=%b expected ovf=0 af=1",
                     o_overflow[0], o_almost_full[0]);
        end
        i_ready = 1'b1;
        i_data  = {16'h0, 16'h68};
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_overflow[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_write_pop: got ovf=%b expected 0", o_overflow[0]);
        end
        // Buffer should still hold 8, so this write must be dropped.
        i_data = {16'h0, 16'h69};
        tick();
        idle_inputs();
        checks++;
        if (o_overflow[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_still_8: got ovf=%b expected 1", o_overflow[0]);
        end
        i_ready = 1'b1;
        repeat (15) tick();
        check_q_size("full_pop_drain", 10);
        if (q_id.size() == 10) begin
            check_q_entry(0, 1, 16'h6F);
            for (int i = 1; i < 10; i++) begin
                check_q_entry(i, 0, 16'(16'h60 + i - 1));
            end
        end
    endtask

    task automatic test_backpressure_reset();
        logic [DW-1:0] exp0[$];
        logic [DW-1:0] exp1[$];
        logic [DW-1:0] e;
        logic [DW-1:0] prev_d;
        logic          prev_id;
        logic          prev_stall;
        int            seq[N];
        int            stab_err;
        int            order_err;
        seq = '{0, 0};
        do_reset();
        i_mode = 1'b0;
        tick();
        stab_err = 0;
        for (int c = 0; c < 200; c++) begin
            i_ready = 1'($urandom_range(0, 1));
            i_valid = '0;
            for (int k = 0; k < N; k++) begin
                if (!o_almost_full[k] && $urandom_range(0, 2) != 0) begin
                    e = 16'(k * 16'h1000 + seq[k]);
                    seq[k]++;
                    i_data[k*DW +: DW] = e;
                    i_valid[k] = 1'b1;
                    if (k == 0) exp0.push_back(e);
                    else        exp1.push_back(e);
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_d     = o_data;
            prev_id    = o_array_id;
            tick();
            if (prev_stall) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== prev_d || o_array_id !== prev_id) begin
                    errors++;
                    stab_err++;
                    if (stab_err < 5)
                        $display("FAIL stall_stable cycle %0d: got v=%b d=%0h id=%b expected v=1 d=%0h id=%b",
                                 c, o_valid, o_data, o_array_id, prev_d, prev_id);
                end
            end
        end
        idle_inputs();
        i_ready = 1'b1;
        repeat (40) tick();
        check_q_size("bp_total", seq[0] + seq[1]);
        order_err = 0;
        for (int i = 0; i < q_id.size(); i++) begin
            if (q_id[i] == 0 && exp0.size() > 0)      e = exp0.pop_front();
            else if (q_id[i] == 1 && exp1.size() > 0) e = exp1.pop_front();
            else                                       e = 16'hDEAD;
            checks++;
            if (q_data[i] !== e) begin
                errors++;
                order_err++;
                if (order_err < 5)
                    $display("FAIL bp_order[%0d]: got %0h expected %0h", i, q_data[i], e);
            end
        end
        checks++;
        if (o_overflow !== '0) begin
            errors++;
            $display("FAIL bp_no_overflow: got %b expected 00", o_overflow);
        end

        i_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            i_data  = {16'(16'h7100 + i), 16'(16'h7000 + i)};
            i_valid = 2'b11;
            tick();
        end
        idle_inputs();
        checks++;
        if (o_valid !== 1'b1 || o_almost_full !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_state: got v=%b af=%b expected v=1 af=11", o_valid, o_almost_full);
        end
        i_sclr = 1'b1;
        tick();
        i_sclr = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_array_id !== 1'b0 ||
            o_almost_full !== '0 || o_overflow !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b d=%0h id=%b af=%b ovf=%b expected all zero",
                     o_valid, o_data, o_array_id, o_almost_full, o_overflow);
        end
        clear_q();
        i_ready = 1'b1;
        repeat (6) tick();
        check_q_size("reset_discards", 0);
    endtask

    initial begin
        i_sclr      = 1'b1;
        i_mode      = 1'b0;
        i_burst_len = 16'd1;
        i_ready     = 1'b0;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_strict();
        test_almost_full_overflow();
        test_full_write_with_pop();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
